// File: rtl/id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_register
// Description : ID/EX pipeline register for the pipelined MIPS datapath.
//               It captures the decoded control bundle and the decode-stage
//               operands each cycle and presents them to EX. It also detects
//               load-use hazards against the instruction in EX, which stalls
//               PC and IF/ID and inserts a bubble. Taken-branch flushes squash
//               the instruction entering EX.
//
// Ports       :
//   clk                     rising-edge clock
//   reset                   synchronous, active-low reset
//   Flush                   taken branch; squash the instruction entering EX
//   ID_<ctrl>               decode control bits and ALUOp class
//   ID_PC_4 / ID_ReadData1 / ID_ReadData2 / ID_ImmExtend   operands
//   ID_Rs / ID_Rt / ID_Rd   register specifiers
//   EX_*                    registered copies of the ID_* inputs
//   EX_Valid                EX holds a real instruction (0 = bubble)
//   PCWrite / IFID_Write    combinational enables for PC and IF/ID
//   StallCount / FlushCount saturating performance counters
//
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Flush,

    input  logic                      ID_RegDst,
    input  logic                      ID_ALUSrc,
    input  logic                      ID_MemtoReg,
    input  logic                      ID_RegWrite,
    input  logic                      ID_MemRead,
    input  logic                      ID_MemWrite,
    input  logic                      ID_BranchNE,
    input  logic                      ID_BranchEQ,
    input  logic [2:0]                ID_ALUOp,
    input  logic [DATA_WIDTH-1:0]     ID_PC_4,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
    input  logic [DATA_WIDTH-1:0]     ID_ImmExtend,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,

    output logic                      EX_RegDst,
    output logic                      EX_ALUSrc,
    output logic                      EX_MemtoReg,
    output logic                      EX_RegWrite,
    output logic                      EX_MemRead,
    output logic                      EX_MemWrite,
    output logic                      EX_BranchNE,
    output logic                      EX_BranchEQ,
    output logic [2:0]                EX_ALUOp,
    output logic [DATA_WIDTH-1:0]     EX_PC_4,
    output logic [DATA_WIDTH-1:0]     EX_ReadData1,
    output logic [DATA_WIDTH-1:0]     EX_ReadData2,
    output logic [DATA_WIDTH-1:0]     EX_ImmExtend,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rs,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rt,
    output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
    output logic                      EX_Valid,

    output logic                      PCWrite,
    output logic                      IFID_Write,
    output logic [PERF_WIDTH-1:0]     StallCount,
    output logic [PERF_WIDTH-1:0]     FlushCount
);

    localparam logic [PERF_WIDTH-1:0]     c_PERF_ONE = PERF_WIDTH'(1);
    localparam logic [PERF_WIDTH-1:0]     c_PERF_MAX = '1;
    localparam logic [REG_ADDR_WIDTH-1:0] c_REG_ZERO = '0;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                      r_reg_dst;
    logic                      r_alu_src;
    logic                      r_mem_to_reg;
    logic                      r_reg_write;
    logic                      r_mem_read;
    logic                      r_mem_write;
    logic                      r_branch_ne;
    logic                      r_branch_eq;
    logic [2:0]                r_alu_op;
    logic [DATA_WIDTH-1:0]     r_pc_4;
    logic [DATA_WIDTH-1:0]     r_read_data1;
    logic [DATA_WIDTH-1:0]     r_read_data2;
    logic [DATA_WIDTH-1:0]     r_imm_extend;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_valid;
    logic [PERF_WIDTH-1:0]     r_stall_count;
    logic [PERF_WIDTH-1:0]     r_flush_count;

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    logic w_uses_rt;
    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_stall;
    logic w_bubble;

    // Immediate-form ALU ops take their second operand from the immediate,
    // so rt is only a source for R-type instructions and stores.
    assign w_uses_rt  = ~ID_ALUSrc | ID_MemWrite;
    assign w_rs_match = (r_rt == ID_Rs);
    assign w_rt_match = (r_rt == ID_Rt) & w_uses_rt;

    // r0 is hardwired to zero, so a load targeting it can never feed
    // a dependent instruction.
    assign w_hazard = r_valid & r_mem_read & (r_rt != c_REG_ZERO) &
                      (w_rs_match | w_rt_match);

    // A flush takes precedence: the held instruction is being squashed
    // anyway, so the redirect must be allowed to proceed.
    assign w_stall  = w_hazard & ~Flush;
    assign w_bubble = Flush | w_hazard;

    assign PCWrite    = ~w_stall;
    assign IFID_Write = ~w_stall;

    // ------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg_dst     <= 1'b0;
            r_alu_src     <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_branch_ne   <= 1'b0;
            r_branch_eq   <= 1'b0;
            r_alu_op      <= 3'b000;
            r_pc_4        <= '0;
            r_read_data1  <= '0;
            r_read_data2  <= '0;
            r_imm_extend  <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_rd          <= '0;
            r_valid       <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            // Operand and specifier fields always follow decode; a bubble
            // is defined purely by its cleared control bits and valid flag.
            r_pc_4       <= ID_PC_4;
            r_read_data1 <= ID_ReadData1;
            r_read_data2 <= ID_ReadData2;
            r_imm_extend <= ID_ImmExtend;
            r_rs         <= ID_Rs;
            r_rt         <= ID_Rt;
            r_rd         <= ID_Rd;

            if (w_bubble) begin
                r_reg_dst    <= 1'b0;
                r_alu_src    <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_branch_ne  <= 1'b0;
                r_branch_eq  <= 1'b0;
                r_alu_op     <= 3'b000;
                r_valid      <= 1'b0;
            end else begin
                r_reg_dst    <= ID_RegDst;
                r_alu_src    <= ID_ALUSrc;
                r_mem_to_reg <= ID_MemtoReg;
                r_reg_write  <= ID_RegWrite;
                r_mem_read   <= ID_MemRead;
                r_mem_write  <= ID_MemWrite;
                r_branch_ne  <= ID_BranchNE;
                r_branch_eq  <= ID_BranchEQ;
                r_alu_op     <= ID_ALUOp;
                r_valid      <= 1'b1;
            end

            // Counters stick at all-ones so long runs never alias to small values.
            if (Flush && (r_flush_count != c_PERF_MAX)) begin
                r_flush_count <= r_flush_count + c_PERF_ONE;
            end
            if (w_stall && (r_stall_count != c_PERF_MAX)) begin
                r_stall_count <= r_stall_count + c_PERF_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign EX_RegDst    = r_reg_dst;
    assign EX_ALUSrc    = r_alu_src;
    assign EX_MemtoReg  = r_mem_to_reg;
    assign EX_RegWrite  = r_reg_write;
    assign EX_MemRead   = r_mem_read;
    assign EX_MemWrite  = r_mem_write;
    assign EX_BranchNE  = r_branch_ne;
    assign EX_BranchEQ  = r_branch_eq;
    assign EX_ALUOp     = r_alu_op;
    assign EX_PC_4      = r_pc_4;
    assign EX_ReadData1 = r_read_data1;
    assign EX_ReadData2 = r_read_data2;
    assign EX_ImmExtend = r_imm_extend;
    assign EX_Rs        = r_rs;
    assign EX_Rt        = r_rt;
    assign EX_Rd        = r_rd;
    assign EX_Valid     = r_valid;
    assign StallCount   = r_stall_count;
    assign FlushCount   = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_register
// Description : Scoreboard bench for id_ex_stage_register. Each driven cycle
//               pushes the expected EX state, computed from an independent
//               model, and the entry is popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_register;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 5;

    // Control bundle packing: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,
    //                          MemWrite,BranchNE,BranchEQ,ALUOp[2:0]}
    localparam logic [10:0] c_RTYPE = 11'b1_0_0_1_0_0_0_0_111;
    localparam logic [10:0] c_LW    = 11'b0_1_1_1_1_0_0_0_000;
    localparam logic [10:0] c_ADDI  = 11'b0_1_0_1_0_0_0_0_001;
    localparam logic [10:0] c_SW    = 11'b0_1_0_0_0_1_0_0_000;

    typedef struct {
        logic [10:0]  ctrl;
        logic         valid;
        logic [4*DW+3*AW-1:0] data;
        logic [PW-1:0] sc;
        logic [PW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, Flush;
    logic [10:0] id_ctrl;
    logic [DW-1:0] ID_PC_4, ID_ReadData1, ID_ReadData2, ID_ImmExtend;
    logic [AW-1:0] ID_Rs, ID_Rt, ID_Rd;

    logic EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead;
    logic EX_MemWrite, EX_BranchNE, EX_BranchEQ, EX_Valid, PCWrite, IFID_Write;
    logic [2:0] EX_ALUOp;
    logic [DW-1:0] EX_PC_4, EX_ReadData1, EX_ReadData2, EX_ImmExtend;
    logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd;
    logic [PW-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    // Model of the EX-side state, evolved only from the bench's own expectations
    logic          m_known = 1'b0;
    logic          m_valid, m_memread;
    logic [AW-1:0] m_rt;
    logic [PW-1:0] m_sc, m_fc;

    always #5 clk = ~clk;

    id_ex_stage_register #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .PERF_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .ID_RegDst(id_ctrl[10]), .ID_ALUSrc(id_ctrl[9]), .ID_MemtoReg(id_ctrl[8]),
        .ID_RegWrite(id_ctrl[7]), .ID_MemRead(id_ctrl[6]), .ID_MemWrite(id_ctrl[5]),
        .ID_BranchNE(id_ctrl[4]), .ID_BranchEQ(id_ctrl[3]), .ID_ALUOp(id_ctrl[2:0]),
        .ID_PC_4(ID_PC_4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_ImmExtend(ID_ImmExtend), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_BranchNE(EX_BranchNE), .EX_BranchEQ(EX_BranchEQ), .EX_ALUOp(EX_ALUOp),
        .EX_PC_4(EX_PC_4), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
        .EX_ImmExtend(EX_ImmExtend), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_Valid(EX_Valid), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic set_id(input logic [10:0] ctrl, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        id_ctrl      = ctrl;
        ID_Rs        = rs;
        ID_Rt        = rt;
        ID_Rd        = rd;
        ID_PC_4      = $urandom;
        ID_ReadData1 = $urandom;
        ID_ReadData2 = $urandom;
        ID_ImmExtend = $urandom;
    endtask

    // One clock: check the combinational enables, push the expected EX state,
    // let the edge happen, then pop and compare.
    task automatic step(input string name);
        exp_t e, got;
        logic uses, hz, exp_pcw;
        #1;
        uses    = !id_ctrl[9] || id_ctrl[5];
        hz      = m_known && m_valid && m_memread && (m_rt != 0) &&
                  ((m_rt == ID_Rs) || ((m_rt == ID_Rt) && uses));
        exp_pcw = Flush || !hz;
        if (m_known) begin
            checks++;
            if (PCWrite !== exp_pcw || IFID_Write !== exp_pcw) begin
                errors++;
                $display("FAIL %s enables: PCWrite=%b IFID_Write=%b expected %b",
                         name, PCWrite, IFID_Write, exp_pcw);
            end
        end
        e.data = {ID_PC_4, ID_ReadData1, ID_ReadData2, ID_ImmExtend, ID_Rs, ID_Rt, ID_Rd};
        if (!reset) begin
            e.ctrl = '0; e.valid = 1'b0; e.data = '0; e.sc = '0; e.fc = '0;
        end else begin
            e.sc = m_sc; e.fc = m_fc;
            if (Flush) begin
                e.ctrl = '0; e.valid = 1'b0;
                if (m_fc != {PW{1'b1}}) e.fc = m_fc + 1'b1;
            end else if (hz) begin
                e.ctrl = '0; e.valid = 1'b0;
                if (m_sc != {PW{1'b1}}) e.sc = m_sc + 1'b1;
            end else begin
                e.ctrl = id_ctrl; e.valid = 1'b1;
            end
        end
        q.push_back(e);
        if (!reset) m_known = 1'b1;
        m_valid = e.valid; m_memread = e.ctrl[6]; m_rt = ID_Rt;
        if (!reset) m_rt = '0;
        m_sc = e.sc; m_fc = e.fc;

        @(posedge clk);
        #1;
        e = q.pop_front();
        got.ctrl = {EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead,
                    EX_MemWrite, EX_BranchNE, EX_BranchEQ, EX_ALUOp};
        got.data = {EX_PC_4, EX_ReadData1, EX_ReadData2, EX_ImmExtend, EX_Rs, EX_Rt, EX_Rd};
        checks++;
        if (got.ctrl !== e.ctrl || EX_Valid !== e.valid) begin
            errors++;
            $display("FAIL %s ctrl: got ctrl=%b valid=%b expected ctrl=%b valid=%b",
                     name, got.ctrl, EX_Valid, e.ctrl, e.valid);
        end
        checks++;
        if (got.data !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, got.data, e.data);
        end
        checks++;
        if (StallCount !== e.sc || FlushCount !== e.fc) begin
            errors++;
            $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, StallCount, FlushCount, e.sc, e.fc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; Flush = 1'b0;
        set_id(11'h7FF, 5'd9, 5'd9, 5'd9);
        step("reset0");
        set_id(c_LW, 5'd3, 5'd9, 5'd1);
        step("reset1");
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_pass_through();
        set_id(c_RTYPE, 5'd8, 5'd9, 5'd10);
        step("pass_rtype");
        set_id(c_SW, 5'd2, 5'd5, 5'd0);
        step("pass_sw");
        set_id(11'b0_0_0_0_0_0_1_1_010, 5'd6, 5'd7, 5'd0);
        step("pass_branch");
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(c_LW, 5'd1, 5'd9, 5'd0);
        step("lu_load");
        set_id(c_RTYPE, 5'd9, 5'd3, 5'd4);
        step("lu_stall");
        step("lu_advance");
        step("lu_after");
        // store that reads the loaded register through rt
        set_id(c_LW, 5'd1, 5'd12, 5'd0);
        step("lu_load2");
        set_id(c_SW, 5'd2, 5'd12, 5'd0);
        step("lu_sw_stall");
        step("lu_sw_advance");
    endtask

    task automatic test_no_false_stall();
        do_reset();
        set_id(c_LW, 5'd1, 5'd9, 5'd0);
        step("nfs_load");
        set_id(c_ADDI, 5'd4, 5'd9, 5'd0);
        step("nfs_addi");
        set_id(c_LW, 5'd1, 5'd0, 5'd0);
        step("nfs_load_r0");
        set_id(c_RTYPE, 5'd0, 5'd0, 5'd5);
        step("nfs_r0_use");
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_id(c_LW, 5'd1, 5'd9, 5'd0);
        step("fp_load");
        set_id(c_RTYPE, 5'd9, 5'd9, 5'd4);
        Flush = 1'b1;
        step("fp_flush_hazard");
        Flush = 1'b0;
        set_id(c_RTYPE, 5'd8, 5'd9, 5'd10);
        step("fp_resume");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(c_LW, 5'd1, 5'd9, 5'd0);
        step("rms_load");
        set_id(c_RTYPE, 5'd9, 5'd3, 5'd4);
        reset = 1'b0;
        step("rms_reset_in_stall");
        step("rms_reset_hold");
        reset = 1'b1;
        step("rms_resume");
    endtask

    // Dependent loads: each pair stalls once and the chain keeps moving.
    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_id(c_LW, 5'd9, 5'd9, 5'd0);
            step("b2b");
        end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        n = (1 << PW) + 3;
        set_id(c_LW, 5'd9, 5'd9, 5'd0);
        for (int i = 0; i < 2 * n + 1; i++) begin
            set_id(c_LW, 5'd9, 5'd9, 5'd0);
            step("sat");
        end
        checks++;
        if (StallCount !== {PW{1'b1}}) begin
            errors++;
            $display("FAIL sat_final: StallCount=%h expected %h", StallCount, {PW{1'b1}});
        end
    endtask

    initial begin
        reset = 1'b0;
        Flush = 1'b0;
        set_id('0, '0, '0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_reset_mid_stall();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline stage for the pipelined MIPS datapath, directly downstream of the decode control unit. Each cycle it captures the decoded control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp) together with decode-stage operands, and presents them to EX. It also detects load-use hazards against the instruction currently in EX, stalls PC and IF/ID, and inserts bubbles. Flushes from taken branches are applied here as well.

## Interface
- DATA_WIDTH, 32, width of the register operands, immediate and PC+4
- REG_ADDR_WIDTH, 5, width of the register specifiers
- PERF_WIDTH, 16, width of the stall and flush performance counters

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- Flush  in  1  branch taken; squash the instruction entering EX
- ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_BranchNE, ID_BranchEQ  in  1 each  control bits from decode
- ID_ALUOp  in  3  ALU operation class from decode
- ID_PC_4, ID_ReadData1, ID_ReadData2, ID_ImmExtend  in  DATA_WIDTH each  decode-stage operands
- ID_Rs, ID_Rt, ID_Rd  in  REG_ADDR_WIDTH each  register specifiers
- EX_* (one per ID_* input)  out  same width  registered copy
- EX_Valid  out  1  EX holds a real instruction (0 = bubble)
- PCWrite  out  1  PC may advance (combinational)
- IFID_Write  out  1  IF/ID may load (combinational)
- StallCount, FlushCount  out  PERF_WIDTH each  saturating event counters

## Operation
- Hazard = EX_Valid & EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | ((EX_Rt == ID_Rt) & UsesRt)).
- UsesRt = !ID_ALUSrc | ID_MemWrite. Immediate ALU ops do not read rt. R-type instructions and stores do.
- Next-state selection, with priority Flush > Hazard > normal:
  - Flush: all EX control bits load 0 and EX_Valid loads 0. FlushCount increments. PCWrite=1 and IFID_Write=1 so the redirect proceeds.
  - Hazard (no Flush): a bubble is inserted, with control bits 0 and EX_Valid 0. PCWrite=0 and IFID_Write=0, so the load-use instruction is held in ID. StallCount increments.
  - Normal: all EX_* load their ID_* values, EX_Valid loads 1, PCWrite=1 and IFID_Write=1.
- Data fields (EX_PC_4, EX_ReadData*, EX_ImmExtend, EX_Rs/Rt/Rd) always load their ID values, including during a bubble or flush. Control bits alone determine architectural effect.
- Both counters saturate at all-ones and never wrap.
- After a one-cycle stall, the bubble in EX has EX_Valid=0, which clears Hazard. The held instruction then advances on the next edge. This gives exactly one stall cycle per load-use pair.

## Timing
- Latency: 1 cycle from ID_* to EX_*.
- Hazard, PCWrite and IFID_Write are combinational from EX_* registers and ID_* inputs within the same cycle. There is no registered delay.
- Reset (reset=0 at an edge):
  - All EX_* outputs, EX_Valid, StallCount and FlushCount become 0.
  - Reset overrides Flush and Hazard.
  - Reset asserted mid-stall discards the held state. While reset is low, PCWrite=1 and IFID_Write=1 because EX_Valid=0.
- Flush and Hazard in the same cycle: the flush action is taken. Only FlushCount increments. PCWrite=1.
- Back-to-back loads, where a load depends on the preceding load: one stall each, no deadlock.
- EX_Rt == 0 never stalls.

## Test plan
- Reset: hold reset=0 for 2 edges with arbitrary ID inputs -> all EX_* = 0, EX_Valid=0, counters 0, PCWrite=1, IFID_Write=1.
- Pass-through: ID is an R-type with ALUOp=3'b111, RegDst=1, RegWrite=1, Rs=8, Rt=9, Rd=10 -> the next cycle shows EX matching those values with EX_Valid=1, and no stall.
- Load-use: EX holds a lw with Rt=9 and MemRead=1; ID is an R-type with Rs=9 -> PCWrite=0 and IFID_Write=0 this cycle. The next EX is a bubble with EX_Valid=0, RegWrite=0 and StallCount=1. The following cycle the R-type enters EX.
- No false stall: EX is a lw with Rt=9; ID is an addi with Rs=4 and Rt=9 (ALUSrc=1) -> no stall. Repeat with EX_Rt=0 and ID_Rs=0 -> no stall.
- Flush priority: a load-use hazard and Flush=1 in the same cycle -> the next EX is a bubble, FlushCount=1, StallCount=0, PCWrite=1.
- Saturation: force 2^PERF_WIDTH+3 stalls -> StallCount holds 16'hFFFF.
